// File: rtl/mmio_input_hub_pkg.sv
// Shared definitions for the memory-mapped input hub: register offsets and window decode.
package mmio_input_hub_pkg;

    localparam int IH_WIN_BITS = 5;

    localparam logic [2:0] IH_LEVEL   = 3'd0;
    localparam logic [2:0] IH_PENDING = 3'd1;
    localparam logic [2:0] IH_ENABLE  = 3'd2;
    localparam logic [2:0] IH_EDGE    = 3'd3;
    localparam logic [2:0] IH_COUNT   = 3'd4;
    localparam logic [2:0] IH_RAWSYNC = 3'd5;

    function automatic logic window_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:IH_WIN_BITS] == base[31:IH_WIN_BITS];
    endfunction

endpackage

// File: rtl/mmio_input_hub_debounce_ch.sv
// One input channel: two-flop synchroniser followed by a stable-count debouncer.
module input_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic stable,
    output logic update
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic [CW-1:0] cnt;

    // update is combinational so the top can flag an event on the same edge stable flips
    assign update = (sync != stable) && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_input_hub.sv
// Memory-mapped input hub: debounced channels, sticky W1C pending bits, irq and event counter.
module mmio_input_hub
    import mmio_input_hub_pkg::*;
#(
    parameter int          N_CH            = 5,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_F100,
    parameter int          CNT_W           = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [N_CH-1:0] din,
    output logic            irq
);

    logic [N_CH-1:0]  sync_vec;
    logic [N_CH-1:0]  level;
    logic [N_CH-1:0]  update_vec;
    logic [N_CH-1:0]  evt_vec;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  enable;
    logic [N_CH-1:0]  edge_mode;
    logic [CNT_W-1:0] event_cnt;

    logic       hit;
    logic [2:0] sel;
    logic       wr_pending;
    logic       wr_enable;
    logic       wr_edge;
    logic       wr_count;
    logic       unused_bits;

    assign hit        = window_hit(addr, BASE_ADDR);
    assign sel        = addr[4:2];
    assign wr_pending = we && hit && (sel == IH_PENDING);
    assign wr_enable  = we && hit && (sel == IH_ENABLE);
    assign wr_edge    = we && hit && (sel == IH_EDGE);
    assign wr_count   = we && hit && (sel == IH_COUNT);
    assign unused_bits = ^{addr[1:0], wdata};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        input_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .din   (din[i]),
            .sync  (sync_vec[i]),
            .stable(level[i]),
            .update(update_vec[i])
        );
    end

    // The new level equals sync on an update; EDGE=0 wants a 1, EDGE=1 wants a 0
    assign evt_vec = update_vec & (sync_vec ^ edge_mode);
    assign irq     = |(pending & enable);

    // Event OR-in after the W1C mask so a coincident event keeps its bit set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            enable    <= '0;
            edge_mode <= '0;
        end else begin
            if (wr_enable) enable <= wdata[N_CH-1:0];
            if (wr_edge) edge_mode <= wdata[N_CH-1:0];
            pending <= (pending & ~(wr_pending ? wdata[N_CH-1:0] : {N_CH{1'b0}})) | evt_vec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_cnt <= '0;
        end else if (wr_count) begin
            event_cnt <= '0;
        end else if ((|evt_vec) && (event_cnt != {CNT_W{1'b1}})) begin
            event_cnt <= event_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (sel)
                IH_LEVEL:   rdata = 32'(level);
                IH_PENDING: rdata = 32'(pending);
                IH_ENABLE:  rdata = 32'(enable);
                IH_EDGE:    rdata = 32'(edge_mode);
                IH_COUNT:   rdata = 32'(event_cnt);
                IH_RAWSYNC: rdata = 32'(sync_vec);
                default:    rdata = '0;
            endcase
        end
    end

endmodule
